mult_div_issue_block: RTL and testbench



---
 rtl/mult_div_issue_block_if.sv | 22 ++
 rtl/mult_div_issue_block.sv | 83 ++++++++
 tb/tb_mult_div_issue_block.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_issue_block_if.sv
// mult_div_issue_block_if: issue-queue and CDB handshake bundle for the mult/div issue block
interface mult_div_issue_block_if #(parameter int XLEN = 32, parameter int TAG_W = 6);
  logic             issueque_ready;
  logic [2:0]       issue_opcode;
  logic [TAG_W-1:0] issue_rd_tag;
  logic [XLEN-1:0]  issue_rs1_data;
  logic [XLEN-1:0]  issue_rs2_data;
  logic             issueblk_done;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             busy;
  modport slave (
    input  issueque_ready, issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data, cdb_grant,
    output issueblk_done, cdb_req, cdb_tag, cdb_data, busy
  );
  modport master (
    output issueque_ready, issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data, cdb_grant,
    input  issueblk_done, cdb_req, cdb_tag, cdb_data, busy
  );
endinterface

// File: rtl/mult_div_issue_block.sv
// mult_div_issue_block: iterative RV32M multiply/divide between issue queue and CDB; MULT_DIV_FAST_MUL_EN enables single-cycle multiply
module mult_div_issue_block #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mult_div_issue_block_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [4:0]        cnt;
  logic [2:0]        op, opc;
  logic [TAG_W-1:0]  rd;
  logic [2*XLEN-1:0] acc, fprod, prod;
  logic [XLEN-1:0]   b, rs1, rs2, m1, m2, quo, rmd, res;
  logic              neg_q, neg_r, s1, s2, n1, n2, div0, ovf, fast, accept;
  logic [XLEN:0]     msum;
  logic [XLEN+1:0]   dif;
  assign opc = bus.issue_opcode;
  assign rs1 = bus.issue_rs1_data;
  assign rs2 = bus.issue_rs2_data;
  assign s1 = opc == 3'd1 || opc == 3'd2 || opc == 3'd4 || opc == 3'd6;
  assign s2 = opc == 3'd1 || opc == 3'd4 || opc == 3'd6;
  assign n1 = s1 & rs1[XLEN-1];
  assign n2 = s2 & rs2[XLEN-1];
  assign m1 = n1 ? -rs1 : rs1;
  assign m2 = n2 ? -rs2 : rs2;
  assign div0 = opc[2] && rs2 == '0;
  assign ovf = (opc == 3'd4 || opc == 3'd6) && rs1 == 32'h8000_0000 && rs2 == '1;
`ifdef MULT_DIV_FAST_MUL_EN
  assign fast  = !opc[2];
  assign fprod = {32'b0, m1} * {32'b0, m2};
`else
  assign fast  = 1'b0;
  assign fprod = '0;
`endif
  assign bus.issueblk_done = rst_n && state == IDLE;
  assign accept = bus.issueblk_done && bus.issueque_ready;
  // multiply: multiplier in acc low half, partial sum in high half, shift right
  assign msum = acc[0] ? {1'b0, acc[63:32]} + {1'b0, b} : {1'b0, acc[63:32]};
  // divide: remainder in high half, dividend/quotient bits shift through low half
  assign dif = {1'b0, acc[63:31]} - {2'b0, b};
  assign prod = neg_q ? -acc : acc;
  assign quo = neg_q ? -acc[31:0] : acc[31:0];
  assign rmd = neg_r ? -acc[63:32] : acc[63:32];
  assign res = op == 3'd0 ? prod[31:0] : !op[2] ? prod[63:32] : op[1] ? rmd : quo;
  always_comb begin
    state_n = state == IDLE ? (accept ? (div0 || ovf || fast ? FIX : EXEC) : IDLE) :
              state == EXEC ? (&cnt ? FIX : EXEC) :
              state == FIX  ? DONE :
              (bus.cdb_grant ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.cdb_req <= 1'b0;
      bus.cdb_tag <= '0;
      bus.cdb_data <= '0;
    end else begin
      state    <= state_n;
      bus.busy <= state_n != IDLE;
      cnt      <= state == EXEC ? cnt + 5'd1 : 5'd0;
      if (accept) begin
        op    <= opc;
        rd    <= bus.issue_rd_tag;
        b     <= m2;
        neg_q <= !(div0 || ovf) && (n1 ^ n2);
        neg_r <= !(div0 || ovf) && opc[2] && n1;
        acc   <= div0 ? {rs1, 32'hFFFF_FFFF} : ovf ? {32'b0, 32'h8000_0000} : fast ? fprod : {32'b0, m1};
      end else if (state == EXEC)
        acc <= op[2] ? (dif[XLEN+1] ? {acc[62:0], 1'b0} : {dif[31:0], acc[30:0], 1'b1}) : {msum, acc[31:1]};
      if (state == FIX) begin
        bus.cdb_req  <= 1'b1;
        bus.cdb_tag  <= rd;
        bus.cdb_data <= res;
      end else if (state == DONE && bus.cdb_grant)
        bus.cdb_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_div_issue_block.sv
// tb_mult_div_issue_block: directed checks of latency, results, back-pressure and reset for mult_div_issue_block
module tb_mult_div_issue_block;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
`ifdef MULT_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  mult_div_issue_block_if #(.XLEN(32), .TAG_W(6)) bus ();
  mult_div_issue_block #(.XLEN(32), .TAG_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    bus.issueque_ready = 1'b1;
    bus.issue_opcode = op;
    bus.issue_rs1_data = a;
    bus.issue_rs2_data = b;
    bus.issue_rd_tag = tag;
    step();
    bus.issueque_ready = 1'b0;
  endtask

  task automatic wait_req(input int start, output int lat);
    lat = start;
    while (!bus.cdb_req && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic grant();
    bus.cdb_grant = 1'b1;
    step();
    bus.cdb_grant = 1'b0;
  endtask

  task automatic test_reset();
    bus.issueque_ready = 1'b1;
    bus.cdb_grant = 1'b0;
    bus.issue_opcode = 3'd0;
    bus.issue_rd_tag = 6'h0;
    bus.issue_rs1_data = 32'h0;
    bus.issue_rs2_data = 32'h0;
    rst_n = 1'b0;
    step();
    step();
    tests++; if (bus.issueblk_done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", bus.issueblk_done); end
    tests++; if (bus.cdb_req !== 1'b0) begin fails++; $display("FAIL reset req: got %b want 0", bus.cdb_req); end
    tests++; if (bus.cdb_tag !== 6'h0) begin fails++; $display("FAIL reset tag: got %h want 00", bus.cdb_tag); end
    tests++; if (bus.cdb_data !== 32'h0) begin fails++; $display("FAIL reset data: got %h want 0", bus.cdb_data); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    bus.issueque_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    tests++; if (bus.issueblk_done !== 1'b1) begin fails++; $display("FAIL release done: got %b want 1", bus.issueblk_done); end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'd0, 3'd3, 3'd2, 3'd1};
    logic [31:0] av [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bv [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000};
    logic [31:0] ev [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i], 6'(6'h15 + i));
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mul[%0d] busy: got %b want 1", i, bus.busy); end
      wait_req(1, lat);
      tests++; if (lat != MUL_LAT) begin fails++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, MUL_LAT); end
      tests++; if (bus.cdb_data !== ev[i]) begin fails++; $display("FAIL mul[%0d] data: got %h want %h", i, bus.cdb_data, ev[i]); end
      tests++; if (bus.cdb_tag !== 6'(6'h15 + i)) begin fails++; $display("FAIL mul[%0d] tag: got %h want %h", i, bus.cdb_tag, 6'(6'h15 + i)); end
      grant();
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  ops [5] = '{3'd5, 3'd6, 3'd7, 3'd4, 3'd6};
    logic [31:0] av [5] = '{32'd100, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], av[i], bv[i], 6'(i + 1));
      wait_req(1, lat);
      tests++; if (lat != 2) begin fails++; $display("FAIL special[%0d] latency: got %0d want 2", i, lat); end
      tests++; if (bus.cdb_data !== ev[i]) begin fails++; $display("FAIL special[%0d] data: got %h want %h", i, bus.cdb_data, ev[i]); end
      grant();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd7, 3'd5};
    logic [31:0] av [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd100};
    logic [31:0] bv [4] = '{32'd2, 32'd2, 32'd2, 32'd7};
    logic [31:0] ev [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd14};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i], 6'(6'h20 + i));
      lat = 1;
      if (i == 0) begin
        bus.cdb_grant = 1'b1;
        repeat (3) step();
        bus.cdb_grant = 1'b0;
        lat = 4;
      end
      wait_req(lat, lat);
      tests++; if (lat != 34) begin fails++; $display("FAIL div[%0d] latency: got %0d want 34", i, lat); end
      tests++; if (bus.cdb_data !== ev[i]) begin fails++; $display("FAIL div[%0d] data: got %h want %h", i, bus.cdb_data, ev[i]); end
      grant();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(3'd5, 32'd100, 32'd7, 6'h03);
    wait_req(1, lat);
    tests++; if (lat != 34) begin fails++; $display("FAIL hold latency: got %0d want 34", lat); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.cdb_req !== 1'b1 || bus.cdb_tag !== 6'h03 || bus.cdb_data !== 32'd14 || bus.issueblk_done !== 1'b0) begin
        fails++; $display("FAIL hold[%0d]: got req=%b tag=%h data=%h done=%b want req=1 tag=03 data=0000000e done=0", i, bus.cdb_req, bus.cdb_tag, bus.cdb_data, bus.issueblk_done);
      end
      step();
    end
    bus.cdb_grant = 1'b1;
    step();
    bus.cdb_grant = 1'b0;
    tests++; if (bus.cdb_req !== 1'b0 || bus.issueblk_done !== 1'b1) begin
      fails++; $display("FAIL after grant: got req=%b done=%b want req=0 done=1", bus.cdb_req, bus.issueblk_done);
    end
    issue(3'd3, 32'hFFFF_FFFF, 32'd3, 6'h2A);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b accept busy: got %b want 1", bus.busy); end
    wait_req(1, lat);
    tests++; if (lat != MUL_LAT) begin fails++; $display("FAIL b2b latency: got %0d want %0d", lat, MUL_LAT); end
    tests++; if (bus.cdb_data !== 32'd2 || bus.cdb_tag !== 6'h2A) begin
      fails++; $display("FAIL b2b result: got data=%h tag=%h want data=00000002 tag=2a", bus.cdb_data, bus.cdb_tag);
    end
    grant();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic seen;
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 6'h09);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    tests++; if (bus.cdb_req !== 1'b0 || bus.cdb_tag !== 6'h0 || bus.cdb_data !== 32'h0 || bus.busy !== 1'b0 || bus.issueblk_done !== 1'b0) begin
      fails++; $display("FAIL midop reset: got req=%b tag=%h data=%h busy=%b done=%b want all 0", bus.cdb_req, bus.cdb_tag, bus.cdb_data, bus.busy, bus.issueblk_done);
    end
    rst_n = 1'b1;
    #1;
    tests++; if (bus.issueblk_done !== 1'b1) begin fails++; $display("FAIL midop release done: got %b want 1", bus.issueblk_done); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= bus.cdb_req;
      step();
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midop discarded: got req seen=%b want 0", seen); end
    issue(3'd7, 32'd7, 32'd2, 6'h11);
    wait_req(1, lat);
    tests++; if (lat != 34 || bus.cdb_data !== 32'd1 || bus.cdb_tag !== 6'h11) begin
      fails++; $display("FAIL midop next op: got lat=%0d data=%h tag=%h want lat=34 data=00000001 tag=11", lat, bus.cdb_data, bus.cdb_tag);
    end
    grant();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_special();
    test_div();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
